// File: rtl/pool_core.sv
// 2x2 stride-2 signed int8 max-pooling engine over a packed feature-map BRAM.
// Optional build macro POOL_RELU_EN: clamp negative result lanes to zero on write.
module pool_core #(
  parameter int unsigned FM_W     = 8,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned IN_BASE  = 0,
  parameter int unsigned OUT_BASE = 256
) (
  input  logic              PCLK,
  input  logic              PRESETB,
  input  logic              pool_start,
  output logic              pool_done,
  output logic [31:0]       clk_counter,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data
);

  localparam int unsigned HALF  = FM_W / 2;
  localparam int unsigned IDX_W = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q,   state_d;
  logic [1:0]        k_q,       k_d;
  logic [IDX_W-1:0]  r_q,       r_d;
  logic [IDX_W-1:0]  c_q,       c_d;
  logic [31:0]       acc_q,     acc_d;
  logic [31:0]       cnt_q,     cnt_d;
  logic              done_q,    done_d;
  logic              rd_en_q,   rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              last_win;

  function automatic logic [31:0] lane_max(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    m = a;
    for (int i = 0; i < 4; i++) begin
      if ($signed(b[8*i +: 8]) > $signed(a[8*i +: 8])) m[8*i +: 8] = b[8*i +: 8];
    end
    return m;
  endfunction

  function automatic logic [31:0] out_fmt(input logic [31:0] v);
    logic [31:0] o;
    o = v;
`ifdef POOL_RELU_EN
    for (int i = 0; i < 4; i++) begin
      if (v[8*i+7]) o[8*i +: 8] = 8'h00;
    end
`endif
    return o;
  endfunction

  function automatic logic [ADDR_W-1:0] in_addr(input logic [IDX_W-1:0] r,
                                                 input logic [IDX_W-1:0] c,
                                                 input logic [1:0]       k);
    int unsigned row;
    int unsigned col;
    row = 2 * 32'(r) + 32'(k[1]);
    col = 2 * 32'(c) + 32'(k[0]);
    return ADDR_W'(IN_BASE + row * FM_W + col);
  endfunction

  function automatic logic [ADDR_W-1:0] out_addr(input logic [IDX_W-1:0] r,
                                                  input logic [IDX_W-1:0] c);
    return ADDR_W'(OUT_BASE + 32'(r) * HALF + 32'(c));
  endfunction

  assign last_win = (r_q == IDX_W'(HALF - 1)) && (c_q == IDX_W'(HALF - 1));

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    r_d       = r_q;
    c_d       = c_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;

    case (state_q)
      S_IDLE: begin
        if (pool_start) begin
          state_d = S_RD;
          k_d     = 2'd0;
          r_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
        end
      end
      S_RD: begin
        cnt_d = cnt_q + 32'd1;
        k_d   = k_q + 2'd1;
        // Read data lags rd_en by one cycle, so element k-1 arrives at step k
        if (k_q == 2'd1)      acc_d = rd_data;
        else if (k_q != 2'd0) acc_d = lane_max(acc_q, rd_data);
        if (k_q == 2'd3) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        cnt_d   = cnt_q + 32'd1;
        acc_d   = lane_max(acc_q, rd_data);
        state_d = S_WR;
      end
      S_WR: begin
        cnt_d = cnt_q + 32'd1;
        if (last_win) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
          k_d     = 2'd0;
          if (c_q == IDX_W'(HALF - 1)) begin
            c_d = '0;
            r_d = r_q + IDX_W'(1);
          end else begin
            c_d = c_q + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        if (!pool_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_RD) begin
      rd_en_d   = 1'b1;
      rd_addr_d = in_addr(r_d, c_d, k_d);
    end
    if (state_d == S_WR) begin
      wr_en_d   = 1'b1;
      wr_addr_d = out_addr(r_d, c_d);
      wr_data_d = out_fmt(acc_d);
    end
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      r_q       <= r_d;
      c_q       <= c_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign pool_done   = done_q;
  assign clk_counter = cnt_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

endmodule
